// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding four requesters' bytes to one UART transmitter.
// Ports:
//   clock, rst            - system clock, synchronous active-high reset
//   req[3:0]              - per-requester level request (sampled only while idle)
//   req_data[31:0]        - byte for requester i at [8i+7:8i]
//   req_cfg[23:0]         - {baud_rate[1:0], parity_type[1:0], stop_bits, data_length} at [6i+5:6i]
//   ack[3:0], done[3:0]   - one-cycle grant / frame-complete pulses
//   err                   - one-cycle pulse when tx_active never arrives
//   busy                  - high whenever a frame is in flight or in the inter-frame gap
//   tx_*                  - registered strobe, byte and config to the transmitter
//   tx_active, tx_done    - transmitter status
module uart_tx_scheduler #(
    parameter int SEND_CYCLES = 5,
    parameter int GAP_CYCLES  = 2,
    parameter int ACT_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [23:0] req_cfg,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic        err,
    output logic        busy,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_baud_rate,
    output logic [1:0]  tx_parity_type,
    output logic        tx_stop_bits,
    output logic        tx_data_length,
    input  logic        tx_active,
    input  logic        tx_done
);
    localparam int MAX_SG = SEND_CYCLES > GAP_CYCLES ? SEND_CYCLES : GAP_CYCLES;
    localparam int MAXC   = MAX_SG > ACT_TIMEOUT ? MAX_SG : ACT_TIMEOUT;
    localparam int CW     = MAXC < 1 ? 1 : $clog2(MAXC + 1);
    // Zero-length phases still occupy one cycle.
    localparam logic [CW-1:0] SEND_LAST = CW'(SEND_CYCLES > 0 ? SEND_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ACT_LAST  = CW'(ACT_TIMEOUT > 0 ? ACT_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACT, WAIT_DONE, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    last, last_n, win, idx;
    logic          found;
    logic [3:0]    ack_n, done_n;
    logic          err_n, send_n;
    logic [7:0]    data_n;
    logic [5:0]    cfg_n;

    // Search starts one past the last winner; last also names the requester owning the current frame.
    always_comb begin
        win   = last + 2'd1;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        ack_n   = '0;
        done_n  = '0;
        err_n   = 1'b0;
        send_n  = 1'b0;
        data_n  = tx_data;
        cfg_n   = {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length};
        case (state)
            IDLE: if (found) begin
                state_n    = SEND;
                cnt_n      = '0;
                last_n     = win;
                ack_n[win] = 1'b1;
                send_n     = 1'b1;
                data_n     = req_data[8*win +: 8];
                cfg_n      = req_cfg[6*win +: 6];
            end
            SEND: if (cnt == SEND_LAST) begin
                state_n = WAIT_ACT;
                cnt_n   = '0;
            end else begin
                cnt_n  = cnt + 1'b1;
                send_n = 1'b1;
            end
            WAIT_ACT: if (tx_active) begin
                state_n = WAIT_DONE;
                cnt_n   = '0;
            end else if (cnt == ACT_LAST) begin
                state_n = GAP;
                cnt_n   = '0;
                err_n   = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            WAIT_DONE: if (!tx_active && tx_done) begin
                state_n      = GAP;
                cnt_n        = '0;
                done_n[last] = 1'b1;
            end
            GAP: if (cnt == GAP_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 2'd3;
            ack     <= '0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            tx_send <= 1'b0;
            tx_data <= '0;
            {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            last    <= last_n;
            ack     <= ack_n;
            done    <= done_n;
            err     <= err_n;
            busy    <= state_n != IDLE;
            tx_send <= send_n;
            tx_data <= data_n;
            {tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length} <= cfg_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized scenario bench for uart_tx_scheduler with a round-robin reference model.
module tb_uart_tx_scheduler;
    localparam int SEND_CYCLES = 5;
    localparam int GAP_CYCLES  = 2;
    localparam int ACT_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [23:0] req_cfg = '0;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  ack, done;
    logic        err, busy, tx_send;
    logic [7:0]  tx_data;
    logic [1:0]  tx_baud_rate, tx_parity_type;
    logic        tx_stop_bits, tx_data_length;

    int checks = 0;
    int passes = 0;
    int m_last = 3;
    int multi = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .SEND_CYCLES(SEND_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .ACT_TIMEOUT(ACT_TIMEOUT)
    ) dut (
        .clock(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_cfg(req_cfg),
        .ack(ack),
        .done(done),
        .err(err),
        .busy(busy),
        .tx_send(tx_send),
        .tx_data(tx_data),
        .tx_baud_rate(tx_baud_rate),
        .tx_parity_type(tx_parity_type),
        .tx_stop_bits(tx_stop_bits),
        .tx_data_length(tx_data_length),
        .tx_active(tx_active),
        .tx_done(tx_done)
    );

    always @(negedge clk) if (!rst && (!$onehot0(ack) || !$onehot0(done))) multi++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic logic [13:0] out_word();
        return {tx_data, tx_baud_rate, tx_parity_type, tx_stop_bits, tx_data_length};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            tick;
            if (ack !== 4'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_frame;
        for (int i = 0; i < 20 && tx_send === 1'b1; i++) tick;
        tx_active = 1'b1;
        tick;
        tx_active = 1'b0;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({ack, done, err, busy, tx_send, out_word()} !== 25'd0)
            $display("FAIL reset_values: got %h expected 0", {ack, done, err, busy, tx_send, out_word()});
        else passes++;
        rst = 1'b0;
        m_last = 3;
    endtask

    task automatic test_single(input int r, input logic [7:0] d, input logic [5:0] c);
        int lat, n, ackx, chg, bad, exp_w;
        req_data = $urandom;
        req_cfg = 24'($urandom);
        req_data[8*r +: 8] = d;
        req_cfg[6*r +: 6] = c;
        req = 4'b0001 << r;
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        m_last = exp_w;
        checks++;
        if (lat !== 1) $display("FAIL single_latency: got %0d expected 1", lat); else passes++;
        checks++;
        if (ack !== 4'b0001 << exp_w) $display("FAIL single_ack: got %b expected %b", ack, 4'b0001 << exp_w); else passes++;
        checks++;
        if (out_word() !== {d, c}) $display("FAIL single_latch: got %h expected %h", out_word(), {d, c}); else passes++;
        checks++;
        if ({tx_send, busy} !== 2'b11) $display("FAIL single_send_start: got %b expected 11", {tx_send, busy}); else passes++;
        n = 1; ackx = 0; chg = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ack !== 4'b0) ackx++;
            if (out_word() !== {d, c}) chg++;
            if (tx_send !== 1'b1) break;
            n++;
        end
        checks++;
        if (n !== SEND_CYCLES) $display("FAIL single_send_len: got %0d expected %0d", n, SEND_CYCLES); else passes++;
        checks++;
        if (ackx !== 0) $display("FAIL single_ack_width: got %0d extra cycles expected 0", ackx); else passes++;
        repeat ($urandom_range(0, 3)) begin
            tick;
            if (done !== 4'b0 || err !== 1'b0) bad++;
        end
        tx_active = 1'b1;
        repeat ($urandom_range(1, 4)) begin
            tick;
            if (done !== 4'b0 || err !== 1'b0) bad++;
            if (out_word() !== {d, c}) chg++;
        end
        tx_active = 1'b0;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0001 << exp_w) $display("FAIL single_done: got %b expected %b", done, 4'b0001 << exp_w); else passes++;
        n = 0;
        for (int i = 0; i < 10 && busy === 1'b1; i++) begin
            n++;
            tick;
            if (done !== 4'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (n !== GAP_CYCLES) $display("FAIL single_gap_len: got %0d expected %0d", n, GAP_CYCLES); else passes++;
        checks++;
        if ({bad, chg} !== 64'd0) $display("FAIL single_spurious: got bad=%0d changes=%0d expected 0", bad, chg); else passes++;
    endtask

    task automatic test_round_robin;
        int lat, exp_w;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_last = 3;
        req_data = $urandom;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_w = rr_pick(req);
            wait_ack(lat);
            if (k == 4) req = '0;
            checks++;
            if (ack !== 4'b0001 << exp_w || tx_data !== req_data[8*exp_w +: 8])
                $display("FAIL rr_grant_%0d: got ack=%b data=%h expected ack=%b data=%h", k, ack, tx_data, 4'b0001 << exp_w, req_data[8*exp_w +: 8]);
            else passes++;
            m_last = exp_w;
            tick;
            checks++;
            if (ack !== 4'b0) $display("FAIL rr_ack_width_%0d: got %b expected 0000", k, ack); else passes++;
            finish_frame;
        end
    endtask

    task automatic test_random;
        int lat, exp_w;
        logic [3:0] r4;
        for (int k = 0; k < 8; k++) begin
            req_data = $urandom;
            req_cfg = 24'($urandom);
            r4 = 4'($urandom_range(1, 15));
            req = r4;
            exp_w = rr_pick(r4);
            wait_ack(lat);
            req = '0;
            checks++;
            if (ack !== 4'b0001 << exp_w || out_word() !== {req_data[8*exp_w +: 8], req_cfg[6*exp_w +: 6]})
                $display("FAIL random_grant_%0d: req=%b got ack=%b word=%h expected ack=%b word=%h", k, r4, ack, out_word(),
                         4'b0001 << exp_w, {req_data[8*exp_w +: 8], req_cfg[6*exp_w +: 6]});
            else passes++;
            m_last = exp_w;
            finish_frame;
        end
    endtask

    task automatic test_late_request;
        int lat, exp_w, bad;
        bad = 0;
        req = 4'b0001;
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        m_last = exp_w;
        tx_done = 1'b1;
        for (int i = 0; i < 20 && tx_send === 1'b1; i++) begin
            tick;
            if (done !== 4'b0) bad++;
        end
        repeat (2) begin
            tick;
            if (done !== 4'b0) bad++;
        end
        tx_active = 1'b1;
        tick;
        req = 4'b0100;
        repeat (3) begin
            tick;
            if (done !== 4'b0 || ack !== 4'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL late_stale_done: got %0d spurious pulses expected 0", bad); else passes++;
        tx_active = 1'b0;
        tick;
        tx_done = 1'b0;
        checks++;
        if (done !== 4'b0001 << exp_w) $display("FAIL late_done: got %b expected %b", done, 4'b0001 << exp_w); else passes++;
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        checks++;
        if (lat !== GAP_CYCLES + 1) $display("FAIL late_ack_delay: got %0d expected %0d", lat, GAP_CYCLES + 1); else passes++;
        checks++;
        if (ack !== 4'b0001 << exp_w) $display("FAIL late_ack: got %b expected %b", ack, 4'b0001 << exp_w); else passes++;
        m_last = exp_w;
        finish_frame;
    endtask

    task automatic test_timeout;
        int lat, exp_w, n, bad;
        bad = 0;
        n = -1;
        req = 4'b0001 << $urandom_range(0, 3);
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        m_last = exp_w;
        for (int i = 0; i < 20 && tx_send === 1'b1; i++) tick;
        for (int i = 1; i <= ACT_TIMEOUT + 50; i++) begin
            tick;
            if (done !== 4'b0) bad++;
            if (err === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== ACT_TIMEOUT) $display("FAIL timeout_delay: got %0d expected %0d", n, ACT_TIMEOUT); else passes++;
        tick;
        if (done !== 4'b0) bad++;
        checks++;
        if (err !== 1'b0 || bad !== 0) $display("FAIL timeout_pulse: got err=%b done_pulses=%0d expected 0 0", err, bad); else passes++;
        req = 4'b1111;
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        checks++;
        if (ack !== 4'b0001 << exp_w) $display("FAIL timeout_next_grant: got %b expected %b", ack, 4'b0001 << exp_w); else passes++;
        m_last = exp_w;
        finish_frame;
    endtask

    task automatic test_reset_mid;
        int lat, exp_w;
        req = 4'b0001 << $urandom_range(0, 3);
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        m_last = exp_w;
        for (int i = 0; i < 20 && tx_send === 1'b1; i++) tick;
        tx_active = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        tx_active = 1'b0;
        tx_done = 1'b1;
        tick;
        checks++;
        if ({ack, done, err, busy, tx_send, out_word()} !== 25'd0)
            $display("FAIL reset_mid_values: got %h expected 0", {ack, done, err, busy, tx_send, out_word()});
        else passes++;
        rst = 1'b0;
        tx_done = 1'b0;
        m_last = 3;
        req = 4'b1111;
        exp_w = rr_pick(req);
        wait_ack(lat);
        req = '0;
        checks++;
        if (ack !== 4'b0001 << exp_w || lat !== 1 || done !== 4'b0 || err !== 1'b0)
            $display("FAIL reset_mid_grant: got ack=%b lat=%0d done=%b err=%b expected ack=%b lat=1", ack, lat, done, err, 4'b0001 << exp_w);
        else passes++;
        m_last = exp_w;
        finish_frame;
    endtask

    task automatic test_exclusive;
        checks++;
        if (multi !== 0) $display("FAIL exclusive_pulses: got %0d multi-hot cycles expected 0", multi); else passes++;
    endtask

    initial begin
        test_reset;
        test_single(0, 8'hAA, 6'b100001);
        test_single($urandom_range(0, 3), 8'($urandom), 6'($urandom));
        test_round_robin;
        test_random;
        test_late_request;
        test_timeout;
        test_reset_mid;
        test_exclusive;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
